if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Fetch-stage PC controller, downstream of the AXI instruction reader.
//  Drives inst_addr/inst_addr_valid and consumes inst/inst_valid.
//  Buffers {pc,inst} pairs in a 2-entry queue feeding the IF/ID register; handles redirects from EX.
//  Fetch is strictly sequential; one instruction is accepted per cycle at most.
// PARAMETERS
//  ADDR_WIDTH  64            PC / address width
//  RESET_PC    64'h80000000  first fetch address after reset
//  Q_DEPTH     2             output queue entries (power of 2, >=2)
// PORTS
//  clk              in   1           rising-edge clock
//  rst_n            in   1           asynchronous active-low reset
//  inst_addr_valid  out  1           fetch request valid to the instruction reader
//  inst_addr        out  ADDR_WIDTH  current fetch PC, 4-byte aligned
//  inst             in   32          instruction for inst_addr
//  inst_valid       in   1           inst valid for the current inst_addr (combinational upstream)
//  redirect_valid   in   1           branch/jump/trap redirect, single-cycle pulse
//  redirect_pc      in   ADDR_WIDTH  redirect target
//  if_id_valid      out  1           queue head valid
//  if_id_pc         out  ADDR_WIDTH  queue head PC
//  if_id_inst       out  32          queue head instruction
//  if_id_ready      in   1           decode accepts the head this cycle
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - pc=RESET_PC; state=S_BOOT; queue empty.
//   - inst_addr_valid=0, if_id_valid=0, if_id_pc=0, if_id_inst=32'h00000013 (NOP).
//  States:
//   - S_BOOT: inst_addr_valid=0 for one cycle, then S_FETCH.
//   - S_FETCH: inst_addr_valid=1, inst_addr=pc.
//   - S_REDIR: inst_addr_valid=0 for exactly one cycle, then S_FETCH. This makes the reader see a
//     line miss and return to idle before a new request is issued.
//  pop    = if_id_valid & if_id_ready.
//  accept = (state==S_FETCH) & inst_valid & ~redirect_valid & (count<Q_DEPTH | pop).
//   - On accept: push {pc,inst}; pc <= pc+4 (wraps modulo 2^ADDR_WIDTH).
//   - Latency: inst_valid to if_id_valid is one cycle.
//  Redirect (any state except S_BOOT):
//   - pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}.
//   - Queue flushed: count=0, pointers=0, and any pop in that cycle is ignored.
//   - Same-cycle inst_valid is dropped. Next state = S_REDIR.
//  Redirect during S_BOOT: pc is loaded and the state still goes to S_FETCH.
//  Back-to-back redirects: the last one wins and S_REDIR is re-entered.
//  Queue:
//   - Circular buffer with wr_ptr, rd_ptr, count[$clog2(Q_DEPTH):0].
//   - if_id_valid = (count!=0); head fields are read directly from rd_ptr.
//   - Full with pop: push and pop happen in the same cycle and count is unchanged.
//   - Empty: no pop, and head fields hold their last values.
//   - Count never exceeds Q_DEPTH and never underflows (assertions required).
//  inst_addr changes only on accept or redirect and is stable while inst_valid=0.
//  Reset asserted mid-operation: all state is cleared immediately and fetch resumes via S_BOOT.
// STRUCTURE
//  - top_defines.v: RESET_PC default, NOP encoding 32'h00000013, state encodings
//    S_BOOT=2'd0, S_FETCH=2'd1, S_REDIR=2'd2.
//  - Sub-module if_fetch_queue: parameterised FIFO holding {pc,inst}, with push, pop,
//    flush, count, head outputs and async active-low reset.
//  - This file holds only the FSM, the PC register and the accept logic.
// TESTING
//  1 Reset: release rst_n -> inst_addr_valid=0 for 1 cycle, then 1 with inst_addr=0x80000000.
//  2 Stream: inst_valid=1 for 4 cycles, if_id_ready=1 -> if_id_pc 0x80000000..0x8000000C in order,
//    each one cycle after its accept.
//  3 Backpressure: if_id_ready=0, inst_valid=1 -> 2 accepts, then pc held at 0x80000008;
//    ready=1 -> accept and pop in the same cycle, count stays 2.
//  4 Redirect: redirect_valid with redirect_pc=0x80001006 and inst_valid=1 in the same cycle
//    -> no push, queue empty next cycle, one cycle of inst_addr_valid=0, then inst_addr=0x80001004.
//  5 Redirect with full queue and if_id_ready=1 -> no pop counted, if_id_valid=0 next cycle.
//  6 Reset pulsed mid-stream (async, not clock-aligned) -> outputs at reset values immediately,
//    then scenario 1 sequence.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the fetch-stage PC controller.
package if_fetch_ctrl_pkg;

    localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_REDIR = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_queue.sv
// Small circular buffer of {pc,inst} pairs feeding the IF/ID register.
module if_fetch_queue
    import if_fetch_ctrl_pkg::*;
#(
    parameter int AW    = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [AW-1:0]            push_pc_i,
    input  logic [31:0]              push_inst_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     head_valid_o,
    output logic [AW-1:0]            head_pc_o,
    output logic [31:0]              head_inst_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] mem_pc_q   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] last_pc_q;
    logic [31:0]   last_inst_q;
    logic          not_empty;
    logic          do_push, do_pop;

    assign not_empty = (count_q != '0);
    assign do_push   = push_i & ~flush_i;
    assign do_pop    = pop_i & not_empty & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_pc_q   <= '0;
            last_inst_q <= NOP_INST;
        end else begin
            // Remember what the head showed so an empty queue keeps presenting it.
            if (not_empty) begin
                last_pc_q   <= mem_pc_q[rd_ptr_q];
                last_inst_q <= mem_inst_q[rd_ptr_q];
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                if (do_push && !do_pop)      count_q <= count_q + CW'(1);
                else if (!do_push && do_pop) count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pc_q[wr_ptr_q]   <= push_pc_i;
            mem_inst_q[wr_ptr_q] <= push_inst_i;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (count_q <= FULL);
            assert (!(pop_i && !flush_i && count_q == '0));
            assert (!(push_i && !flush_i && !pop_i && count_q == FULL));
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = not_empty;
    assign head_pc_o    = not_empty ? mem_pc_q[rd_ptr_q]   : last_pc_q;
    assign head_inst_o  = not_empty ? mem_inst_q[rd_ptr_q] : last_inst_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage PC controller: boot/fetch/redirect FSM, PC register and accept logic.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC),
    parameter int                    Q_DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  inst_addr_valid,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [31:0]           inst,
    input  logic                  inst_valid,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_id_valid,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic [31:0]           if_id_inst,
    input  logic                  if_id_ready
);

    localparam int CW = $clog2(Q_DEPTH) + 1;
    localparam logic [CW-1:0] Q_FULL = CW'(Q_DEPTH);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  addr_vld_q;
    logic [CW-1:0]         q_count;
    logic                  pop, accept, flush;
    logic [ADDR_WIDTH-1:0] redir_aligned;

    assign redir_aligned = redirect_pc & ~ADDR_WIDTH'(3);
    assign pop    = if_id_valid & if_id_ready;
    assign accept = (state_q == S_FETCH) & inst_valid & ~redirect_valid
                  & ((q_count != Q_FULL) | pop);
    // The boot cycle never holds queued entries, so only later redirects flush.
    assign flush  = redirect_valid & (state_q != S_BOOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            addr_vld_q <= 1'b0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q    <= S_FETCH;
                    addr_vld_q <= 1'b1;
                    if (redirect_valid) pc_q <= redir_aligned;
                end
                default: begin
                    if (redirect_valid) begin
                        state_q    <= S_REDIR;
                        addr_vld_q <= 1'b0;
                        pc_q       <= redir_aligned;
                    end else begin
                        state_q    <= S_FETCH;
                        addr_vld_q <= 1'b1;
                        if (accept) pc_q <= pc_q + ADDR_WIDTH'(4);
                    end
                end
            endcase
        end
    end

    assign inst_addr_valid = addr_vld_q;
    assign inst_addr       = pc_q;

    if_fetch_queue #(
        .AW    (ADDR_WIDTH),
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (accept),
        .push_pc_i    (pc_q),
        .push_inst_i  (inst),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (q_count),
        .head_valid_o (if_id_valid),
        .head_pc_o    (if_id_pc),
        .head_inst_o  (if_id_inst)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed table-driven bench for the fetch-stage PC controller.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        inst_addr_valid;
    logic [63:0] inst_addr;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_addr_valid (inst_addr_valid),
        .inst_addr       (inst_addr),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_inst      (if_id_inst),
        .if_id_ready     (if_id_ready)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        e_avl;
        logic [63:0] e_ia;
        logic        e_v;
        logic [63:0] e_hp;
        logic [31:0] e_hi;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic avl, input logic [63:0] ia,
                           input logic v, input logic [63:0] hp, input logic [31:0] hi);
        chk({tag, ".inst_addr_valid"}, 64'(inst_addr_valid), 64'(avl));
        chk({tag, ".inst_addr"},       inst_addr,            ia);
        chk({tag, ".if_id_valid"},     64'(if_id_valid),     64'(v));
        chk({tag, ".if_id_pc"},        if_id_pc,             hp);
        chk({tag, ".if_id_inst"},      64'(if_id_inst),      64'(hi));
    endtask

    localparam logic [63:0] RPC = 64'h8000_0000;
    localparam logic [63:0] WRP = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        // iv, inst, rv, rpc, rdy | avl, inst_addr, if_id_valid, if_id_pc, if_id_inst
        tbl.push_back('{0, 32'h0, 0, 64'h0, 0,  1, RPC,          0, 64'h0,        NOP});
        tbl.push_back('{1, 32'hA000_0000, 0, 64'h0, 1,  1, RPC + 4,  1, RPC,      32'hA000_0000});
        tbl.push_back('{1, 32'hA000_0001, 0, 64'h0, 1,  1, RPC + 8,  1, RPC + 4,  32'hA000_0001});
        tbl.push_back('{1, 32'hA000_0002, 0, 64'h0, 1,  1, RPC + 12, 1, RPC + 8,  32'hA000_0002});
        tbl.push_back('{1, 32'hA000_0003, 0, 64'h0, 1,  1, RPC + 16, 1, RPC + 12, 32'hA000_0003});
        tbl.push_back('{0, 32'h0, 0, 64'h0, 1,  1, RPC + 16, 0, RPC + 12, 32'hA000_0003});
        tbl.push_back('{0, 32'h0, 0, 64'h0, 0,  1, RPC + 16, 0, RPC + 12, 32'hA000_0003});
        tbl.push_back('{1, 32'hB000_0000, 0, 64'h0, 0,  1, RPC + 20, 1, RPC + 16, 32'hB000_0000});
        tbl.push_back('{1, 32'hB000_0001, 0, 64'h0, 0,  1, RPC + 24, 1, RPC + 16, 32'hB000_0000});
        tbl.push_back('{1, 32'hB000_0002, 0, 64'h0, 0,  1, RPC + 24, 1, RPC + 16, 32'hB000_0000});
        tbl.push_back('{1, 32'hB000_0002, 0, 64'h0, 1,  1, RPC + 28, 1, RPC + 20, 32'hB000_0001});
        tbl.push_back('{0, 32'h0, 0, 64'h0, 0,  1, RPC + 28, 1, RPC + 20, 32'hB000_0001});
        tbl.push_back('{1, 32'hB000_0003, 0, 64'h0, 0,  1, RPC + 28, 1, RPC + 20, 32'hB000_0001});
        tbl.push_back('{1, 32'hC000_0000, 1, 64'h8000_1006, 1,  0, 64'h8000_1004, 0, RPC + 20, 32'hB000_0001});
        tbl.push_back('{1, 32'hC000_0001, 0, 64'h0, 1,  1, 64'h8000_1004, 0, RPC + 20, 32'hB000_0001});
        tbl.push_back('{1, 32'hC000_0002, 0, 64'h0, 1,  1, 64'h8000_1008, 1, 64'h8000_1004, 32'hC000_0002});
        tbl.push_back('{0, 32'h0, 1, 64'h9000_0000, 0,  0, 64'h9000_0000, 0, 64'h8000_1004, 32'hC000_0002});
        tbl.push_back('{0, 32'h0, 1, 64'hA000_0003, 0,  0, 64'hA000_0000, 0, 64'h8000_1004, 32'hC000_0002});
        tbl.push_back('{0, 32'h0, 0, 64'h0, 0,  1, 64'hA000_0000, 0, 64'h8000_1004, 32'hC000_0002});
        tbl.push_back('{0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0,  0, WRP, 0, 64'h8000_1004, 32'hC000_0002});
        tbl.push_back('{0, 32'h0, 0, 64'h0, 0,  1, WRP, 0, 64'h8000_1004, 32'hC000_0002});
        tbl.push_back('{1, 32'hD000_0000, 0, 64'h0, 1,  1, 64'h0, 1, WRP, 32'hD000_0000});
        tbl.push_back('{1, 32'hD000_0001, 0, 64'h0, 0,  1, 64'h4, 1, WRP, 32'hD000_0000});

        #2 rst_n = 1'b0;
        #1 chk_all("reset_async", 1'b0, RPC, 1'b0, 64'h0, NOP);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk_all("boot_cycle", 1'b0, RPC, 1'b0, 64'h0, NOP);

        for (int i = 0; i < tbl.size(); i++) begin
            inst_valid     = tbl[i].iv;
            inst           = tbl[i].ins;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            if_id_ready    = tbl[i].rdy;
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), tbl[i].e_avl, tbl[i].e_ia,
                       tbl[i].e_v, tbl[i].e_hp, tbl[i].e_hi);
        end

        // Asynchronous reset in the middle of a cycle with a non-empty queue.
        #3 rst_n = 1'b0;
        #1 chk_all("midreset", 1'b0, RPC, 1'b0, 64'h0, NOP);
        inst_valid = 1'b0; redirect_valid = 1'b0; if_id_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk_all("midreset_boot", 1'b0, RPC, 1'b0, 64'h0, NOP);

        // Redirect while booting loads the PC and goes straight to fetch.
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        inst_valid = 1'b1; inst = 32'hE000_0000; if_id_ready = 1'b1;
        @(posedge clk);
        #1 chk_all("boot_redirect", 1'b1, 64'h8000_2000, 1'b0, 64'h0, NOP);
        redirect_valid = 1'b0; inst = 32'hE000_0001;
        @(posedge clk);
        #1 chk_all("boot_redirect_fetch", 1'b1, 64'h8000_2004, 1'b1, 64'h8000_2000, 32'hE000_0001);
        inst_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
